// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH = 16;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] QUOT_ON_ZERO = '1;

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor a + ~b + 1; carry-out set means a >= b (no borrow).
module div_trial_sub #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         no_borrow
);

  logic [W:0] sum;

  assign sum       = {1'b0, a} + {1'b0, ~b} + (W + 1)'(1);
  assign diff      = sum[W-1:0];
  assign no_borrow = sum[W];

endmodule

// File: rtl/seq_divider16.sv
// Iterative restoring divider, one quotient bit per cycle, start/busy/done handshake.
// Optional DIV_SIGNED_EN adds sign_mode (two's complement, truncating) with one fix-up cycle.
module seq_divider16
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
  input  logic             sign_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned RW = WIDTH + 1;

  state_t           state;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [RW-1:0]    r_reg;
  logic [CNT_W-1:0] cnt;

  logic [RW-1:0]    shift;
  logic [RW-1:0]    trial;
  logic             no_borrow;
  logic [RW-1:0]    r_next;
  logic [WIDTH-1:0] q_next;

  // Shift in the next dividend bit and compare against the divisor
  assign shift  = RW'({r_reg, q_reg[WIDTH-1]});
  assign r_next = no_borrow ? trial : shift;
  assign q_next = {q_reg[WIDTH-2:0], no_borrow};

  div_trial_sub #(.W(RW)) u_trial (
    .a         (shift),
    .b         ({1'b0, d_reg}),
    .diff      (trial),
    .no_borrow (no_borrow)
  );

`ifdef DIV_SIGNED_EN
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             neg_q, neg_r;

  assign a_neg = sign_mode & dividend[WIDTH-1];
  assign b_neg = sign_mode & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      cnt         <= '0;
`ifdef DIV_SIGNED_EN
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= WIDTH'(QUOT_ON_ZERO);
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              r_reg <= '0;
              cnt   <= CNT_W'(WIDTH);
`ifdef DIV_SIGNED_EN
              q_reg <= a_mag;
              d_reg <= b_mag;
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
`else
              q_reg <= dividend;
              d_reg <= divisor;
`endif
            end
          end
        end

        CALC: begin
`ifdef DIV_SIGNED_EN
          // Counter at zero marks the extra sign fix-up cycle
          if (cnt == '0) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= neg_q ? -q_reg : q_reg;
            remainder   <= neg_r ? -r_reg[WIDTH-1:0] : r_reg[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end else begin
            q_reg <= q_next;
            r_reg <= r_next;
            cnt   <= cnt - CNT_W'(1);
          end
`else
          q_reg <= q_next;
          r_reg <= r_next;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
`endif
        end

        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider16.sv
// Scoreboard bench for seq_divider16: directed vectors, done-cycle and handshake checks.
module tb_seq_divider16;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
`ifdef DIV_SIGNED_EN
  logic        sign_mode;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  seq_divider16 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef DIV_SIGNED_EN
    .sign_mode   (sign_mode),
`endif
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.due));
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        chk("busy_at_done", 32'(busy), 32'(1));
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=%b expected 0", busy);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er,
                       input logic ez, output int n);
    exp_t e;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n       = cyc;
    start   = 1'b0;
    e.q     = eq;
    e.r     = er;
    e.z     = ez;
    e.due   = ez ? n : n + LAT - 1;
    exp_q.push_back(e);
  endtask

  initial begin
    int   n;
    exp_t e;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef DIV_SIGNED_EN
    sign_mode = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_quotient", 32'(quotient), 32'(0));
    chk("rst_remainder", 32'(remainder), 32'(0));
    chk("rst_dbz", 32'(div_by_zero), 32'(0));
    rst_n = 1'b1;

    // Basic case with busy profile over the whole operation
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, n);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      chk("busy_profile", 32'(busy), 32'(k < LAT));
    end

    issue(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, n);
    issue(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, n);
    issue(16'd0, 16'd3, 16'd0, 16'd0, 1'b0, n);
    issue(16'd1234, 16'd0, 16'hFFFF, 16'd1234, 1'b1, n);
    issue(16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, n);
    issue(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, n);
    issue(16'h8000, 16'd3, 16'd10922, 16'd2, 1'b0, n);
    issue(16'd12345, 16'd123, 16'd100, 16'd45, 1'b0, n);

    // Start pulses and operand changes while busy must be ignored
    issue(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, n);
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("hold_quotient", 32'(quotient), 32'(100));
        chk("hold_remainder", 32'(remainder), 32'(45));
      end
      if (k == 3)       begin start = 1'b1; dividend = 16'd7; divisor = 16'd0; end
      if (k == 4)       start = 1'b0;
      if (k == 8)       begin start = 1'b1; dividend = 16'd1; divisor = 16'd1; end
      if (k == 9)       start = 1'b0;
      if (k == LAT - 1) start = 1'b1;
      if (k == LAT)     start = 1'b0;
    end

    // Start held high: one result per LAT+1 cycles
    wait_idle();
    dividend = 16'd40;
    divisor  = 16'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    n = cyc;
    for (int i = 0; i < 3; i++) begin
      e.q   = 16'd6;
      e.r   = 16'd4;
      e.z   = 1'b0;
      e.due = n + LAT - 1 + i * (LAT + 1);
      exp_q.push_back(e);
    end
    repeat (2 * (LAT + 1) + 5) @(negedge clk);
    start = 1'b0;

`ifdef DIV_SIGNED_EN
    sign_mode = 1'b1;
    issue(16'hFFF9, 16'd2, 16'hFFFD, 16'hFFFF, 1'b0, n);
    issue(16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, n);
    issue(16'd7, 16'hFFFE, 16'hFFFD, 16'd1, 1'b0, n);
    issue(16'hFF9C, 16'hFFF9, 16'd14, 16'hFFFE, 1'b0, n);
    issue(16'hFFF9, 16'd0, 16'hFFFF, 16'hFFF9, 1'b1, n);
    sign_mode = 1'b0;
`endif

    // Asynchronous reset in the middle of an operation
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, n);
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_quotient", 32'(quotient), 32'(0));
    chk("midrst_remainder", 32'(remainder), 32'(0));
    chk("midrst_dbz", 32'(div_by_zero), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, n);

    begin
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
        @(negedge clk);
        k++;
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL drain_timeout: got %0d pending results expected 0", exp_q.size());
      end
    end
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
